// File: rtl/obi_apb_ss_bridge.sv
// OBI-to-APB bridge fanning out to NUM_SS equally sized subsystem slots.
// One outstanding transfer; ACCESS phase aborted after TIMEOUT_CYC cycles.
module obi_apb_ss_bridge #(
  parameter int                NUM_SS      = 5,
  parameter int                OBI_AW      = 32,
  parameter int                OBI_DW      = 32,
  parameter int                OBI_IDW     = 1,
  parameter int                APB_AW      = 12,
  parameter logic [OBI_AW-1:0] BASE_ADDR   = 32'h0102_0000,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     obi_req_i,
  output logic                     obi_gnt_o,
  input  logic [OBI_AW-1:0]        obi_addr_i,
  input  logic                     obi_we_i,
  input  logic [OBI_DW/8-1:0]      obi_be_i,
  input  logic [OBI_DW-1:0]        obi_wdata_i,
  input  logic [OBI_IDW-1:0]       obi_aid_i,
  output logic                     obi_rvalid_o,
  input  logic                     obi_rready_i,
  output logic [OBI_DW-1:0]        obi_rdata_o,
  output logic                     obi_err_o,
  output logic [OBI_IDW-1:0]       obi_rid_o,
  input  logic [NUM_SS-1:0]        ss_en_i,
  output logic [NUM_SS-1:0]        apb_psel_o,
  output logic                     apb_penable_o,
  output logic [APB_AW-1:0]        apb_paddr_o,
  output logic                     apb_pwrite_o,
  output logic [OBI_DW-1:0]        apb_pwdata_o,
  output logic [OBI_DW/8-1:0]      apb_pstrb_o,
  input  logic [NUM_SS*OBI_DW-1:0] apb_prdata_i,
  input  logic [NUM_SS-1:0]        apb_pready_i,
  input  logic [NUM_SS-1:0]        apb_pslverr_i,
  output logic [7:0]               timeout_cnt_o
);

  localparam int SW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int BW = OBI_DW / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic [APB_AW-1:0]   paddr_q;
  logic                we_q;
  logic [BW-1:0]       be_q;
  logic [OBI_DW-1:0]   wdata_q;
  logic [OBI_DW-1:0]   rdata_q;
  logic [OBI_IDW-1:0]  aid_q;
  logic [SW-1:0]       slot_q;
  logic                err_q;
  logic [15:0]         acc_cnt;
  logic [7:0]          tout_cnt;

  logic [OBI_AW-1:0]   slot_full;
  logic                dec_err;
  logic [NUM_SS-1:0]   psel_vec;
  logic                pready_sel;
  logic                pslverr_sel;
  logic [OBI_DW-1:0]   prdata_sel;
  logic                tout_hit;

  assign slot_full = (obi_addr_i - BASE_ADDR) >> APB_AW;

  // Out-of-range slot indices never reach ss_en_i: the loop only matches real slots.
  always_comb begin
    dec_err = 1'b1;
    if (obi_addr_i >= BASE_ADDR) begin
      for (int k = 0; k < NUM_SS; k++) begin
        if (slot_full == OBI_AW'(k)) dec_err = ~ss_en_i[k];
      end
    end
  end

  always_comb begin
    psel_vec    = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int k = 0; k < NUM_SS; k++) begin
      if (slot_q == SW'(k)) begin
        psel_vec[k] = 1'b1;
        pready_sel  = apb_pready_i[k];
        pslverr_sel = apb_pslverr_i[k];
        prdata_sel  = apb_prdata_i[k*OBI_DW +: OBI_DW];
      end
    end
  end

  assign tout_hit = (acc_cnt == 16'(TIMEOUT_CYC));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    obi_gnt_o     = 1'b0;
    obi_rvalid_o  = 1'b0;
    apb_psel_o    = '0;
    apb_penable_o = 1'b0;
    unique case (state)
      IDLE: begin
        obi_gnt_o = ~rst_i;
        if (obi_req_i && !rst_i) state_nxt = dec_err ? RESP : SETUP;
      end
      SETUP: begin
        apb_psel_o = psel_vec;
        state_nxt  = ACCESS;
      end
      ACCESS: begin
        apb_psel_o    = psel_vec;
        apb_penable_o = 1'b1;
        if (pready_sel || tout_hit) state_nxt = RESP;
      end
      RESP: begin
        obi_rvalid_o = 1'b1;
        if (obi_rready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      paddr_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      aid_q    <= '0;
      slot_q   <= '0;
      err_q    <= 1'b0;
      acc_cnt  <= '0;
      tout_cnt <= '0;
    end else begin
      if (state == IDLE && obi_req_i) begin
        paddr_q <= obi_addr_i[APB_AW-1:0];
        we_q    <= obi_we_i;
        be_q    <= obi_be_i;
        wdata_q <= obi_wdata_i;
        aid_q   <= obi_aid_i;
        slot_q  <= slot_full[SW-1:0];
        err_q   <= dec_err;
        rdata_q <= '0;
      end
      if (state == SETUP) acc_cnt <= 16'd1;
      // pready wins over a timeout landing on the same cycle
      if (state == ACCESS) begin
        if (pready_sel) begin
          err_q   <= pslverr_sel;
          rdata_q <= we_q ? '0 : prdata_sel;
        end else if (tout_hit) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
          if (tout_cnt != 8'hFF) tout_cnt <= tout_cnt + 8'd1;
        end else begin
          acc_cnt <= acc_cnt + 16'd1;
        end
      end
    end
  end

  assign apb_paddr_o   = paddr_q;
  assign apb_pwrite_o  = we_q;
  assign apb_pwdata_o  = wdata_q;
  assign apb_pstrb_o   = we_q ? be_q : '0;
  assign obi_rdata_o   = rdata_q;
  assign obi_err_o     = err_q;
  assign obi_rid_o     = aid_q;
  assign timeout_cnt_o = tout_cnt;

endmodule

// File: doc/obi_apb_ss_bridge.md
OBI_APB_SS_BRIDGE -- requirements
Module: obi_apb_ss_bridge

Interface
REQ-001 SHALL have parameter NUM_SS, default 5, number of APB subsystem slots (1..16).
REQ-002 SHALL have parameter OBI_AW, default 32, OBI address width.
REQ-003 SHALL have parameter OBI_DW, default 32, OBI/APB data width.
REQ-004 SHALL have parameter OBI_IDW, default 1, OBI transaction ID width.
REQ-005 SHALL have parameter APB_AW, default 12, per-slot APB address width; slot size is 2^APB_AW bytes.
REQ-006 SHALL have parameter BASE_ADDR, default 32'h0102_0000, byte address of slot 0.
REQ-007 SHALL have parameter TIMEOUT_CYC, default 255, maximum ACCESS cycles before abort (1..65535).
REQ-008 SHALL have ports:
  clk_i  in  1  sole clock, all logic on rising edge
  rst_i  in  1  reset, synchronous, active-high
  obi_req_i  in  1  OBI request
  obi_gnt_o  out  1  OBI grant
  obi_addr_i  in  OBI_AW  byte address
  obi_we_i  in  1  write enable
  obi_be_i  in  OBI_DW/8  byte enables
  obi_wdata_i  in  OBI_DW  write data
  obi_aid_i  in  OBI_IDW  request ID
  obi_rvalid_o  out  1  response valid
  obi_rready_i  in  1  response ready
  obi_rdata_o  out  OBI_DW  read data
  obi_err_o  out  1  response error
  obi_rid_o  out  OBI_IDW  response ID
  ss_en_i  in  NUM_SS  per-slot enable
  apb_psel_o  out  NUM_SS  one-hot slot select
  apb_penable_o  out  1  APB enable
  apb_paddr_o  out  APB_AW  slot-local address
  apb_pwrite_o  out  1  APB write
  apb_pwdata_o  out  OBI_DW  APB write data
  apb_pstrb_o  out  OBI_DW/8  APB strobes
  apb_prdata_i  in  NUM_SS*OBI_DW  per-slot read data, slot k at [k*OBI_DW +: OBI_DW]
  apb_pready_i  in  NUM_SS  per-slot ready
  apb_pslverr_i  in  NUM_SS  per-slot error
  timeout_cnt_o  out  8  saturating count of timed-out transfers

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one outstanding transaction.
REQ-010 SHALL drive obi_gnt_o = 1 exactly when state is IDLE and rst_i is 0; a request is accepted on a cycle with obi_req_i && obi_gnt_o.
REQ-011 On acceptance SHALL register addr, we, be, wdata, aid; slot index = (addr - BASE_ADDR) >> APB_AW.
REQ-012 Decode error SHALL be flagged when addr < BASE_ADDR, or slot index >= NUM_SS, or ss_en_i[slot] is 0 at acceptance; in that case IDLE->RESP with err=1, rdata=0, no psel asserted.
REQ-013 Valid decode SHALL go IDLE->SETUP; SETUP drives psel[slot]=1, penable=0 for exactly one cycle, then ->ACCESS.
REQ-014 ACCESS SHALL drive psel[slot]=1, penable=1; paddr = addr[APB_AW-1:0], pwrite = we, pwdata = wdata, pstrb = be if write else 0; these stay stable SETUP through ACCESS.
REQ-015 In ACCESS with pready[slot]=1 SHALL go ->RESP; err = pslverr[slot]; rdata = prdata slot word if read, 0 if write.
REQ-016 ACCESS counter SHALL start at 1 on first ACCESS cycle; if it equals TIMEOUT_CYC with pready[slot]=0, SHALL go ->RESP with err=1, rdata=0, and increment timeout_cnt_o (saturating at 255).
REQ-017 pready on non-selected slots and pready/pslverr outside ACCESS SHALL be ignored.
REQ-018 RESP SHALL hold obi_rvalid_o=1 with stable rdata/err/rid (rid = registered aid) until obi_rready_i=1, then ->IDLE; obi_rvalid_o=0 outside RESP.
REQ-019 Minimum latency SHALL be: accept cycle N, SETUP N+1, ACCESS N+2, rvalid N+3 when pready at N+2; decode error gives rvalid at N+1.
REQ-020 apb_psel_o SHALL be all-zero and apb_penable_o 0 in IDLE and RESP.

Reset
REQ-021 With rst_i=1 at a rising edge SHALL force IDLE, and all outputs 0 (gnt, rvalid, rdata, err, rid, psel, penable, paddr, pwrite, pwdata, pstrb, timeout_cnt_o) from the next cycle.
REQ-022 Reset mid-transfer SHALL abandon it: psel/penable drop after that edge, no rvalid issued for the abandoned transaction.

Verification
REQ-023 Read slot 2 at BASE_ADDR+0x2010, pready at first ACCESS cycle, prdata=0xCAFE_F00D -> paddr=0x010, rvalid 3 cycles after grant, rdata=0xCAFE_F00D, err=0.
REQ-024 Write 0x1234_5678 be=4'b0011 to slot 0 with pready after 3 wait cycles -> pwrite=1, pstrb=4'b0011, penable high 4 cycles, rvalid with rdata=0, err=0.
REQ-025 Access BASE_ADDR+0x5000 (NUM_SS=5) and slot 1 with ss_en_i[1]=0 -> no psel, rvalid next cycle, err=1, rdata=0.
REQ-026 TIMEOUT_CYC=4, pready held 0 -> penable high exactly 4 cycles, err=1, timeout_cnt_o 0->1; 256 timeouts -> timeout_cnt_o stays 255.
REQ-027 rready held 0 for 5 cycles in RESP, then rst_i pulsed during a later ACCESS -> rvalid/rdata/rid stable 5 cycles; after reset psel=0, rvalid never asserted, gnt=1 once rst_i=0.
